// File: rtl/aes_serial_bridge.sv
// Byte-stream bridge for the AES128 core: assembles key/text frames from an RX
// byte stream, handshakes with the core, and serializes results to a TX stream.
module aes_serial_bridge #(
  parameter logic [7:0] CMD_KEY = 8'h4B,
  parameter logic [7:0] CMD_ENC = 8'h45,
  parameter logic [7:0] CMD_DEC = 8'h44
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic [7:0]   RxData,
  input  logic         RxValid,
  output logic         RxReady,
  output logic [7:0]   TxData,
  output logic         TxValid,
  input  logic         TxReady,
  input  logic         ReadEn,
  input  logic         WriteEn,
  input  logic [127:0] Result,
  output logic [127:0] Key,
  output logic         ReadyKey,
  output logic [127:0] UserText,
  output logic         ProgramSelector,
  output logic         ReadRy,
  output logic         WriteRy,
  output logic         CmdErr
);

  typedef enum logic [1:0] {R_CMD, R_KEY, R_TEXT, R_WAIT} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  rx_state_t    r_rx_state, w_rx_next;
  tx_state_t    r_tx_state, w_tx_next;
  logic [127:0] r_stage, r_key, r_text, r_shift;
  logic [3:0]   r_rx_cnt, r_tx_cnt;
  logic         r_sel_pend, r_sel;
  logic         r_rx_ready, r_ready_key, r_read_ry, r_write_ry, r_cmd_err;
  logic         w_rx_fire, w_tx_fire;
  logic         w_bad_cmd, w_load_key, w_load_text, w_take_result;

  assign w_rx_fire = RxValid & r_rx_ready;
  assign w_tx_fire = (r_tx_state == T_SEND) & TxReady;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rx_state <= R_CMD;
      r_tx_state <= T_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_rx_next   = r_rx_state;
    w_bad_cmd   = 1'b0;
    w_load_key  = 1'b0;
    w_load_text = 1'b0;
    case (r_rx_state)
      R_CMD: begin
        if (w_rx_fire) begin
          if (RxData == CMD_KEY)                             w_rx_next = R_KEY;
          else if ((RxData == CMD_ENC) || (RxData == CMD_DEC)) w_rx_next = R_TEXT;
          else                                               w_bad_cmd = 1'b1;
        end
      end
      R_KEY: begin
        if (w_rx_fire && (r_rx_cnt == 4'd15)) begin
          w_rx_next  = R_CMD;
          w_load_key = 1'b1;
        end
      end
      R_TEXT: begin
        if (w_rx_fire && (r_rx_cnt == 4'd15)) w_rx_next = R_WAIT;
      end
      R_WAIT: begin
        if (ReadEn) begin
          w_rx_next   = R_CMD;
          w_load_text = 1'b1;
        end
      end
      default: w_rx_next = R_CMD;
    endcase
  end

  always_comb begin
    w_tx_next     = r_tx_state;
    w_take_result = 1'b0;
    case (r_tx_state)
      T_IDLE: begin
        if (WriteEn) begin
          w_tx_next     = T_SEND;
          w_take_result = 1'b1;
        end
      end
      T_SEND: begin
        if (TxReady && (r_tx_cnt == 4'd15)) w_tx_next = T_IDLE;
      end
      default: w_tx_next = T_IDLE;
    endcase
  end

  // Ready is registered from the next state, so it drops on the edge entering R_WAIT.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_rx_ready  <= 1'b0;
      r_ready_key <= 1'b0;
      r_read_ry   <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_rx_cnt    <= '0;
      r_stage     <= '0;
      r_key       <= '0;
      r_text      <= '0;
      r_sel_pend  <= 1'b0;
      r_sel       <= 1'b0;
    end else begin
      r_rx_ready  <= (w_rx_next != R_WAIT);
      r_ready_key <= w_load_key;
      r_read_ry   <= w_load_text;
      r_cmd_err   <= w_bad_cmd;
      if ((r_rx_state == R_CMD) && w_rx_fire) begin
        r_rx_cnt <= '0;
        if (RxData == CMD_DEC)      r_sel_pend <= 1'b1;
        else if (RxData == CMD_ENC) r_sel_pend <= 1'b0;
      end
      if (((r_rx_state == R_KEY) || (r_rx_state == R_TEXT)) && w_rx_fire) begin
        r_stage  <= {r_stage[119:0], RxData};
        r_rx_cnt <= r_rx_cnt + 4'd1;
      end
      if (w_load_key) r_key <= {r_stage[119:0], RxData};
      if (w_load_text) begin
        r_text <= r_stage;
        r_sel  <= r_sel_pend;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_write_ry <= 1'b0;
      r_shift    <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_write_ry <= w_take_result;
      if (w_take_result) begin
        r_shift  <= Result;
        r_tx_cnt <= '0;
      end else if (w_tx_fire) begin
        r_shift  <= {r_shift[119:0], 8'h00};
        r_tx_cnt <= r_tx_cnt + 4'd1;
      end
    end
  end

  assign RxReady         = r_rx_ready;
  assign TxData          = r_shift[127:120];
  assign TxValid         = (r_tx_state == T_SEND);
  assign Key             = r_key;
  assign ReadyKey        = r_ready_key;
  assign UserText        = r_text;
  assign ProgramSelector = r_sel;
  assign ReadRy          = r_read_ry;
  assign WriteRy         = r_write_ry;
  assign CmdErr          = r_cmd_err;

endmodule

// File: doc/aes_serial_bridge.md
# aes_serial_bridge

Byte-stream front end for the AES128 core. Assembles key and text frames from an 8-bit valid/ready receive stream, presents them to the core, and answers its read and write handshakes as the serial end. Drives the core's `Key`, `ReadyKey`, `UserText`, `ProgramSelector`, `ReadRy` and `WriteRy` inputs, and consumes its `ReadEn`, `WriteEn` and `Result` outputs. Serializes each 128-bit result back out as 16 bytes on an 8-bit valid/ready transmit stream. Sits between the UART/byte transport and the AES128 top.

## Interface

One clock; reset is asynchronous and active-low.

Parameters:
- `CMD_KEY`, default 8'h4B: command byte opening a 16-byte key frame.
- `CMD_ENC`, default 8'h45: command byte opening a 16-byte text frame to encrypt.
- `CMD_DEC`, default 8'h44: command byte opening a 16-byte text frame to decrypt.

Ports:
- `Clk` — input, 1: clock, rising edge.
- `Rst` — input, 1: asynchronous reset, active-low.
- `RxData` — input, 8: received byte.
- `RxValid` — input, 1: `RxData` valid.
- `RxReady` — output, 1: bridge accepts a byte.
- `TxData` — output, 8: byte to transmit.
- `TxValid` — output, 1: `TxData` valid.
- `TxReady` — input, 1: transport accepts the byte.
- `ReadEn` — input, 1: core requests new text (level).
- `WriteEn` — input, 1: core result valid (level, held until `WriteRy`).
- `Result` — input, 128: core output block.
- `Key` — output, 128: cipher key.
- `ReadyKey` — output, 1: one-cycle pulse, new key loaded.
- `UserText` — output, 128: text block for the core.
- `ProgramSelector` — output, 1: 0 = encrypt, 1 = decrypt.
- `ReadRy` — output, 1: one-cycle pulse, `UserText` and `ProgramSelector` updated.
- `WriteRy` — output, 1: one-cycle pulse, `Result` captured.
- `CmdErr` — output, 1: one-cycle pulse, unknown command byte dropped.

## Operation

- Reset values: all outputs 0. `RxReady` is registered and rises at the first edge after `Rst` releases.
- A byte transfers at a rising edge with `RxValid & RxReady`. A TX byte transfers at a rising edge with `TxValid & TxReady`.
- The RX FSM and TX FSM run concurrently and independently.

RX FSM (R_CMD, R_KEY, R_TEXT, R_WAIT):
- **R_CMD**, on a transferred byte:
  - `CMD_KEY` → R_KEY.
  - `CMD_ENC` / `CMD_DEC` → R_TEXT; a pending-select bit is set to 0 / 1.
  - Any other value → stay in R_CMD, pulse `CmdErr`.
- **R_KEY / R_TEXT**: bytes shift into a 128-bit staging register, first byte ending up in [127:120]. A 4-bit counter counts 0..15.
  - 16th key byte: `Key <= {staging[119:0], RxData}` on that edge; `ReadyKey` high the following cycle; → R_CMD.
  - 16th text byte: staging completes; → R_WAIT.
- **R_WAIT**: `RxReady` = 0. At an edge where `ReadEn` = 1:
  - `UserText <= staging`, `ProgramSelector <= pending-select`.
  - `ReadRy` high for one cycle; → R_CMD.
- `ReadEn` is ignored outside R_WAIT.
- `UserText` and `ProgramSelector` change only on the `ReadRy` edge, so they stay stable while the core processes the block and while the next frame fills staging.
- `RxReady` = 1 in R_CMD, R_KEY and R_TEXT.

TX FSM (T_IDLE, T_SEND):
- **T_IDLE**: at an edge with `WriteEn` = 1:
  - Shift register `<= Result`, counter cleared.
  - `WriteRy` high for one cycle; → T_SEND.
- **T_SEND**: `TxValid` = 1, `TxData` = shift[127:120]. Each TX transfer shifts the register left by 8.
  - 16th transfer → T_IDLE, `TxValid` = 0.
- `WriteEn` is ignored in T_SEND. The core drops `WriteEn` on seeing `WriteRy`; a `WriteEn` still high on return to T_IDLE is a new result.

Boundary behaviour:
- `Rst` asserted mid-frame or mid-transmit: partial frame and partial output are discarded; all registers and outputs return to reset values immediately.
- A key frame may arrive while a text frame waits? No: RX blocks in R_WAIT, so frames are strictly ordered.
- A key frame accepted while the core runs replaces `Key`. Sequencing is the host's responsibility.
- Counters wrap only via the state exit at count 15; no over-length frame is possible.

## Timing

- Key: last byte at edge N → `Key` valid after edge N; `ReadyKey` = 1 during cycle N..N+1.
- Text: last byte at edge N → R_WAIT from edge N. If `ReadEn` = 1 at edge N+1, `ReadRy` = 1 during N+1..N+2 and the next command byte can be accepted from edge N+2.
- Result: `WriteEn` sampled at edge M → `WriteRy` and `TxValid` high from M. With `TxReady` tied to 1, the 16 bytes take edges M+1..M+16 and `TxValid` falls after M+16.
- No combinational path from any input to any output.

## Test plan

- Key frame: `4B`, bytes 00..0F with `RxValid` always high → `Key` = 128'h000102…0F, one `ReadyKey` pulse, `RxReady` held 1 throughout.
- Encrypt frame: `45` + 16×`AA`, `ReadEn` low for 5 cycles then high → `RxReady` = 0 during the wait; then `UserText` = {16{8'hAA}}, `ProgramSelector` = 0, one `ReadRy` pulse.
- Decrypt frame: `44` + 16 bytes, `ReadEn` already high → `ReadRy` exactly 1 cycle after the last byte, `ProgramSelector` = 1.
- Result: `Result` = 128'h00112233…FF, `WriteEn` held until `WriteRy`, `TxReady` toggling 1/0 → `TxData` sequence 00,11,…,FF with no byte repeated or skipped, then `TxValid` = 0.
- Error and reset: byte `7E` in R_CMD → `CmdErr` pulse, state unchanged. Then `4B` + 8 bytes, then `Rst` low → all outputs 0, `Key` still 0. After release, a full key frame loads correctly.
